// File: rtl/stream_demux.sv
// 1-to-N valid/ready stream demultiplexer with packet-level routing and a
// one-entry registered output stage per channel; bad selects are dropped and counted.
//
// state  | meaning
// IDLE   | waiting for a first beat; target comes straight from in_sel
// FWD    | mid-packet, beats routed to the locked channel cur_ch
// DROP   | mid-packet with an invalid select, beats discarded
module stream_demux #(
    parameter int DATA_W = 8,
    parameter int N_CH   = 4,
    parameter int SEL_W  = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [SEL_W-1:0]         in_sel,
    input  logic                     in_last,
    output logic [N_CH-1:0]          out_valid,
    input  logic [N_CH-1:0]          out_ready,
    output logic [N_CH*DATA_W-1:0]   out_data,
    output logic [N_CH-1:0]          out_last,
    output logic [7:0]               drop_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FWD  = 2'd1,
        S_DROP = 2'd2
    } state_t;

    localparam logic [SEL_W:0] N_CH_W = (SEL_W+1)'(N_CH);

    state_t            state, state_nxt;
    logic [SEL_W-1:0]  cur_ch;
    logic [SEL_W-1:0]  tgt_ch;
    logic [N_CH-1:0]   tgt_hot;
    logic [N_CH-1:0]   load;
    logic              sel_ok;
    logic              route_en;
    logic              accept;

    assign sel_ok = ({1'b0, in_sel} < N_CH_W);
    assign tgt_ch = (state == S_FWD) ? cur_ch : in_sel;
    assign accept = in_valid && in_ready;
    assign load   = {N_CH{accept && route_en}} & tgt_hot;

    // One-hot decode avoids indexing out_valid with an out-of-range select.
    always_comb begin
        tgt_hot = '0;
        for (int k = 0; k < N_CH; k++) begin
            tgt_hot[k] = (tgt_ch == SEL_W'(k));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (accept) begin
            case (state)
                S_IDLE: begin
                    if (!in_last) state_nxt = sel_ok ? S_FWD : S_DROP;
                end
                S_FWD, S_DROP: begin
                    if (in_last) state_nxt = S_IDLE;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // A load into a full register is allowed only when it drains the same cycle.
    always_comb begin
        route_en = 1'b0;
        in_ready = 1'b1;
        case (state)
            S_IDLE:  route_en = sel_ok;
            S_FWD:   route_en = 1'b1;
            default: route_en = 1'b0;
        endcase
        if (route_en) begin
            in_ready = |(tgt_hot & (~out_valid | out_ready));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_ch   <= '0;
            drop_cnt <= '0;
        end else if (accept && state == S_IDLE) begin
            if (sel_ok && !in_last) begin
                cur_ch <= in_sel;
            end
            if (!sel_ok && drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= '0;
            out_data  <= '0;
            out_last  <= '0;
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                if (load[k]) begin
                    out_valid[k]                   <= 1'b1;
                    out_data[k*DATA_W +: DATA_W]   <= in_data;
                    out_last[k]                    <= in_last;
                end else if (out_valid[k] && out_ready[k]) begin
                    out_valid[k] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_stream_demux.sv
// Scoreboard bench for stream_demux: a 4-channel instance checked through
// per-channel expected queues, and a 3-channel instance for the drop path.
module tb_stream_demux;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        in_valid, in_ready, in_last;
    logic [7:0]  in_data;
    logic [1:0]  in_sel;
    logic [3:0]  out_valid, out_ready, out_last;
    logic [31:0] out_data;
    logic [7:0]  drop_cnt;

    logic        d3_valid, d3_ready, d3_last;
    logic [7:0]  d3_data;
    logic [1:0]  d3_sel;
    logic [2:0]  d3_ovalid, d3_oready, d3_olast;
    logic [23:0] d3_odata;
    logic [7:0]  d3_drop;

    int n_checks = 0;
    int n_fail   = 0;
    logic [8:0] exp_q [4][$];

    always #5 clk = ~clk;

    stream_demux #(.DATA_W(8), .N_CH(4), .SEL_W(2)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_sel(in_sel), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .drop_cnt(drop_cnt)
    );

    stream_demux #(.DATA_W(8), .N_CH(3), .SEL_W(2)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(d3_valid), .in_ready(d3_ready), .in_data(d3_data),
        .in_sel(d3_sel), .in_last(d3_last),
        .out_valid(d3_ovalid), .out_ready(d3_oready), .out_data(d3_odata),
        .out_last(d3_olast), .drop_cnt(d3_drop)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Present one beat from just after a posedge; returns just after the accepting edge.
    task automatic send_beat(input int ch, input logic [1:0] sel, input logic [7:0] data,
                             input logic last, output int stalls);
        logic acc;
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = data;
        in_last  = last;
        stalls   = 0;
        do begin
            @(negedge clk);
            acc = in_ready;
            if (acc) exp_q[ch].push_back({last, data});
            else stalls++;
            @(posedge clk);
            #1;
        end while (!acc && stalls < 200);
        if (!acc) chk("accept_timeout", 32'(stalls), 32'd0);
    endtask

    task automatic idle_in();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Monitor: every beat consumed by a channel must match the head of its queue.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 4; k++) begin
                if (out_valid[k] && out_ready[k]) begin
                    if (exp_q[k].size() == 0) begin
                        chk($sformatf("unexpected_beat_ch%0d", k), {23'd0, out_last[k], out_data[k*8 +: 8]}, 32'h1FF);
                    end else begin
                        logic [8:0] e;
                        e = exp_q[k].pop_front();
                        chk($sformatf("beat_ch%0d", k), {23'd0, out_last[k], out_data[k*8 +: 8]}, {23'd0, e});
                    end
                end
            end
        end
    end

    initial begin
        int st;
        int total;
        rst_n = 1'b0;
        in_valid = 0; in_data = 0; in_sel = 0; in_last = 0; out_ready = 4'hF;
        d3_valid = 0; d3_data = 0; d3_sel = 0; d3_last = 0; d3_oready = 3'b111;
        #2;
        chk("rst_out_valid", {28'd0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_last", {28'd0, out_last}, 32'd0);
        chk("rst_drop_cnt", {24'd0, drop_cnt}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        in_sel = 2'd3;
        d3_sel = 2'd3;
        #1;
        chk("rst_in_ready_sel3", {31'd0, in_ready}, 32'd1);
        chk("rst_d3_in_ready_bad_sel", {31'd0, d3_ready}, 32'd1);
        in_sel = 2'd0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // basic routing
        for (int k = 0; k < 4; k++) begin
            send_beat(k, 2'(k), 8'hA0 + 8'(k), 1'b1, st);
            chk("basic_no_stall", 32'(st), 32'd0);
        end
        idle_in();
        repeat (3) @(posedge clk); #1;

        // packet lock: select changes after beat 0 are ignored
        send_beat(2, 2'd2, 8'h11, 1'b0, st);
        send_beat(2, 2'd1, 8'h22, 1'b0, st);
        send_beat(2, 2'd1, 8'h33, 1'b1, st);
        idle_in();
        repeat (3) @(posedge clk); #1;

        // back-pressure on channel 1 followed by a packet to channel 3
        out_ready[1] = 1'b0;
        fork
            begin
                send_beat(1, 2'd1, 8'h51, 1'b0, st);
                send_beat(1, 2'd1, 8'h52, 1'b0, st);
                send_beat(1, 2'd1, 8'h53, 1'b0, st);
                send_beat(1, 2'd1, 8'h54, 1'b1, st);
                send_beat(3, 2'd3, 8'h61, 1'b0, st);
                chk("ch3_after_last_no_stall", 32'(st), 32'd0);
                send_beat(3, 2'd0, 8'h62, 1'b1, st);
                idle_in();
            end
            begin
                repeat (4) @(posedge clk);
                @(negedge clk);
                chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
                chk("bp_out_valid1", {31'd0, out_valid[1]}, 32'd1);
                chk("bp_hold_data1", {24'd0, out_data[15:8]}, 32'h51);
                @(posedge clk); #1;
                out_ready[1] = 1'b1;
            end
        join
        repeat (3) @(posedge clk); #1;

        // full throughput: 16 beats, no stalls
        total = 0;
        for (int p = 0; p < 2; p++) begin
            for (int b = 0; b < 8; b++) begin
                send_beat(p, 2'(p), 8'(8'h80 + p*16 + b), (b == 7), st);
                total += st;
            end
        end
        idle_in();
        chk("throughput_stalls", 32'(total), 32'd0);
        repeat (3) @(posedge clk); #1;

        // reset mid-FWD aborts the packet
        out_ready[2] = 1'b0;
        send_beat(2, 2'd2, 8'h77, 1'b0, st);
        idle_in();
        @(negedge clk);
        chk("midfwd_loaded", {31'd0, out_valid[2]}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midfwd_rst_valid", {28'd0, out_valid}, 32'd0);
        chk("midfwd_rst_data", out_data, 32'd0);
        chk("midfwd_rst_in_ready", {31'd0, in_ready}, 32'd1);
        exp_q[2].delete();
        out_ready = 4'hF;
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        send_beat(3, 2'd3, 8'h78, 1'b1, st);
        idle_in();
        repeat (3) @(posedge clk); #1;

        // drop path on the 3-channel instance
        d3_valid = 1'b1; d3_sel = 2'd3; d3_data = 8'hD0; d3_last = 1'b0;
        @(negedge clk);
        chk("drop_ready_b0", {31'd0, d3_ready}, 32'd1);
        @(posedge clk); #1;
        chk("drop_cnt_b0", {24'd0, d3_drop}, 32'd1);
        chk("drop_no_valid_b0", {29'd0, d3_ovalid}, 32'd0);
        d3_sel = 2'd0; d3_data = 8'hD1; d3_last = 1'b1;
        @(negedge clk);
        chk("drop_ready_b1", {31'd0, d3_ready}, 32'd1);
        @(posedge clk); #1;
        chk("drop_cnt_b1", {24'd0, d3_drop}, 32'd1);
        chk("drop_no_valid_b1", {29'd0, d3_ovalid}, 32'd0);
        d3_sel = 2'd2; d3_data = 8'hE2; d3_last = 1'b1;
        @(posedge clk); #1;
        d3_valid = 1'b0;
        chk("d3_route_valid", {29'd0, d3_ovalid}, 32'h4);
        chk("d3_route_data", {24'd0, d3_odata[23:16]}, 32'hE2);
        chk("d3_route_last", {31'd0, d3_olast[2]}, 32'd1);
        @(posedge clk); #1;
        d3_valid = 1'b1; d3_sel = 2'd3; d3_last = 1'b1;
        repeat (253) @(posedge clk);
        #1;
        chk("drop_cnt_254", {24'd0, d3_drop}, 32'd254);
        repeat (46) @(posedge clk);
        #1 d3_valid = 1'b0;
        chk("drop_cnt_sat", {24'd0, d3_drop}, 32'd255);

        repeat (5) @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("queue_empty_ch%0d", k), 32'(exp_q[k].size()), 32'd0);
        end
        chk("drop_cnt_dut4", {24'd0, drop_cnt}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
